// File: rtl/prio_irq_encoder.sv
// Registered priority interrupt encoder: synchronises N request lines, latches
// them as pending events, masks them, and presents the highest-index eligible
// line as an encoded interrupt held until acknowledged.
module prio_irq_encoder #(
  parameter int N          = 8,
  parameter int W          = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int EDGE       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic         irq,
  output logic [W-1:0] code,
  output logic         gs
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t         state_q;
  logic [N-1:0]   r;
  logic [N-1:0]   s1_q, s2_q, s2d_q;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   e;
  logic [N-1:0]   clr;
  logic [W-1:0]   sel;
  logic           irq_q;
  logic [W-1:0]   code_q;
  logic           gs_q;
  logic           ack_acc;

  assign r       = (ACTIVE_LOW != 0) ? ~req : req;
  assign e       = pend_q & ~mask;
  assign ack_acc = (state_q == PRESENT) && ack;
  assign clr     = ack_acc ? (N'(1) << code_q) : '0;

  // set term is OR-ed after the clear so a same-edge re-assertion is kept
  always_comb begin
    pend_d = pend_q;
    if (EDGE != 0) begin
      pend_d = (pend_q & ~clr) | (s2_q & ~s2d_q);
    end else begin
      pend_d = s2_q;
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (e[i]) sel = W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s2d_q  <= '0;
      pend_q <= '0;
      gs_q   <= 1'b0;
    end else begin
      s1_q   <= r;
      s2_q   <= s1_q;
      s2d_q  <= s2_q;
      pend_q <= pend_d;
      gs_q   <= |e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|e) begin
            code_q  <= sel;
            irq_q   <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq  = irq_q;
  assign code = code_q;
  assign gs   = gs_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
module tb_prio_irq_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, mask_a, req_b, mask_b;
  logic       ack_a, ack_b;
  logic       irq_a, irq_b, gs_a, gs_b;
  logic [2:0] code_a, code_b;

  int n_checks;
  int n_pass;

  prio_irq_encoder #(.N(8), .W(3), .ACTIVE_LOW(1), .EDGE(1)) u_edge (
    .clk(clk), .rst(rst), .req(req_a), .mask(mask_a), .ack(ack_a),
    .irq(irq_a), .code(code_a), .gs(gs_a)
  );

  prio_irq_encoder #(.N(8), .W(3), .ACTIVE_LOW(1), .EDGE(0)) u_level (
    .clk(clk), .rst(rst), .req(req_b), .mask(mask_b), .ack(ack_b),
    .irq(irq_b), .code(code_b), .gs(gs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack_a();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
  endtask

  task automatic pulse_ack_b();
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst    = 1'b1;
    req_a  = 8'hFF; req_b  = 8'hFF;
    mask_a = 8'h00; mask_b = 8'h00;
    ack_a  = 1'b0;  ack_b  = 1'b0;

    // 1. reset
    tick(3);
    check("rst_irq", irq_a, 0);
    check("rst_code", code_a, 0);
    check("rst_gs", gs_a, 0);
    rst = 1'b0;
    tick(20);
    check("idle_irq", irq_a, 0);
    check("idle_code", code_a, 0);
    check("idle_gs", gs_a, 0);
    check("idle_irq_lvl", irq_b, 0);

    // 2. priority: lines 7 and 5 asserted
    req_a = 8'b0101_1111;
    tick(3);
    check("lat_irq_e2", irq_a, 0);
    check("lat_gs_e2", gs_a, 0);
    tick();
    check("pri_irq", irq_a, 1);
    check("pri_code7", code_a, 7);
    check("pri_gs", gs_a, 1);
    pulse_ack_a();
    check("pri_gap", irq_a, 0);
    tick();
    check("pri_irq2", irq_a, 1);
    check("pri_code5", code_a, 5);
    pulse_ack_a();
    check("pri_done", irq_a, 0);
    tick();
    check("pri_done2", irq_a, 0);
    check("pri_gs0", gs_a, 0);
    req_a = 8'hFF;
    tick(5);

    // 3. mask hides line 7, which stays pending
    mask_a = 8'h80;
    req_a  = 8'b0101_1111;
    tick(4);
    check("msk_irq", irq_a, 1);
    check("msk_code5", code_a, 5);
    mask_a = 8'h00;
    tick(2);
    check("msk_frozen", code_a, 5);
    pulse_ack_a();
    check("msk_gap", irq_a, 0);
    tick();
    check("msk_irq7", irq_a, 1);
    check("msk_code7", code_a, 7);
    pulse_ack_a();
    tick();
    check("msk_done", irq_a, 0);
    req_a = 8'hFF;
    tick(5);

    // 4. collision: new edge on line 3 on the same edge that acks code 3
    req_a = 8'hF7;
    tick(4);
    check("col_code3", code_a, 3);
    req_a = 8'hFF;
    tick(3);
    req_a = 8'hF7;
    tick(2);
    check("col_still", irq_a, 1);
    pulse_ack_a();
    check("col_gap", irq_a, 0);
    tick();
    check("col_reirq", irq_a, 1);
    check("col_recode", code_a, 3);
    pulse_ack_a();
    req_a = 8'hFF;
    tick(5);
    check("col_done", irq_a, 0);

    // 5. level mode
    req_b = 8'hFB;
    tick(3);
    check("lvl_lat", irq_b, 0);
    tick();
    check("lvl_irq", irq_b, 1);
    check("lvl_code2", code_b, 2);
    pulse_ack_b();
    check("lvl_gap", irq_b, 0);
    tick();
    check("lvl_reirq", irq_b, 1);
    check("lvl_recode", code_b, 2);
    req_b = 8'hFF;
    tick(4);
    check("lvl_gs0", gs_b, 0);
    check("lvl_hold", irq_b, 1);
    pulse_ack_b();
    check("lvl_ackd", irq_b, 0);
    tick(5);
    check("lvl_noirq", irq_b, 0);
    check("ack_idle_edge", irq_a, 0);

    // 6. async reset while presenting, with another line pending
    req_a = 8'b1111_0011;
    tick(4);
    check("ar_irq", irq_a, 1);
    check("ar_code3", code_a, 3);
    check("ar_gs", gs_a, 1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_irq_async", irq_a, 0);
    check("ar_gs_async", gs_a, 0);
    req_a = 8'hFF;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("ar_post_irq", irq_a, 0);
    check("ar_post_gs", gs_a, 0);
    check("ar_post_code", code_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
